countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Downstream consumer of the 1 Hz square wave (`oneHz`) produced by the system clock divider.
- Runs an MM:SS countdown in BCD, controlled by load/start-stop pulses, and flags expiry.
- Outputs feed the seven-segment display driver and the top-level game/alarm logic.
- Entire block sits in the 100 MHz clk domain; `tick_in` is a slow level signal from that same domain.

Parameters:
- MAX_MIN, 99, upper clamp for loaded minutes (must be ≤ 99).
- MAX_SEC, 59, upper clamp for loaded seconds (must be ≤ 59).

Ports:
- clk  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-high reset.
- tick_in  input  1  1 Hz square wave from the divider; each rising edge is one second.
- load  input  1  one-cycle pulse; loads load_min/load_sec and enters IDLE.
- load_min  input  7  binary minutes, 0..127 (clamped to MAX_MIN).
- load_sec  input  6  binary seconds, 0..63 (clamped to MAX_SEC).
- start_stop  input  1  one-cycle pulse (already debounced upstream); toggles run/pause.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of the remaining time.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done_pulse  output  1  one-cycle pulse on the RUN→EXPIRED transition.
- blank  output  1  display blank request (see Optional Feature).

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE; all digits 0; running=0, expired=0, done_pulse=0, blank=0.
  - tick_d=0.
- Tick edge detect:
  - tick_d is a register of tick_in; rise = tick_in & ~tick_d.
  - A decrement occurs on the clk edge where rise=1 (one-cycle latency from the tick_in transition).
- States: IDLE, RUN, PAUSE, EXPIRED.
- Transitions:
  - IDLE --start_stop, time≠00:00--> RUN.
  - IDLE --start_stop, time=00:00--> stays IDLE (ignored).
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - RUN --rise, time=00:01--> EXPIRED.
    - Digits become 00:00 and done_pulse=1 on that same edge.
  - EXPIRED --start_stop--> stays EXPIRED. Only load or RESET leaves EXPIRED.
  - Any state --load--> IDLE with clamped load value.
- Load conversion:
  - min = min(load_min, MAX_MIN); sec = min(load_sec, MAX_SEC).
  - Convert to BCD tens/ones.
  - Digits updated on the same edge as load.
- Decrement (BCD, RUN only, on rise):
  - sec_ones>0: sec_ones-1.
  - else sec_tens>0: sec_tens-1, sec_ones=9.
  - else minutes>0: sec=59, and the minutes decrement with the same borrow rule (min_ones 0 → 9, min_tens-1).
  - Digits never go below 00:00 and never hold a non-BCD value (>9).
- Priority on simultaneous events, highest first:
  1. load
  2. start_stop
  3. rise
- Start/stop coinciding with a tick:
  - start_stop in RUN coincident with rise: go to PAUSE, no decrement.
  - start_stop in PAUSE coincident with rise: go to RUN, no decrement that cycle.
- Ticks outside RUN: rise in IDLE/PAUSE/EXPIRED does nothing.
- Pause/resume: PAUSE holds the digits; RUN resumes from the held value.
- Outputs:
  - done_pulse is registered, exactly one cycle, and 0 in every other cycle.
  - running/expired are registered and decoded from the next state, so they are valid in the same cycle as the state change.
- Reset mid-count: returns to IDLE 00:00 immediately (async); no done_pulse.

Optional Feature:
- Macro: COUNTDOWN_BLINK_EN.
- Defined:
  - blank = ~tick_in while in PAUSE or EXPIRED, so the display flashes at 1 Hz.
  - blank = 0 in IDLE and RUN.
  - blank is registered (one clk lag).
- Not defined: blank is tied to 0 and no blink logic is synthesized.

Test Plan:
- Load 02:05, start_stop, apply 6 tick rises → digits step 02:04, 02:03, 02:02, 02:01, 02:00, 01:59; running=1 throughout.
- Load 00:02, start_stop, 2 rises → 00:01, then 00:00 with expired=1; done_pulse high for exactly 1 clk; further rises and start_stop leave 00:00/EXPIRED.
- Load min=120, sec=63 → digits 99:59 (clamped); start_stop at 00:00 after load of 0/0 → stays IDLE, running=0.
- Running at 00:30: start_stop coincident with rise → PAUSE at 00:30; 3 rises → still 00:30; start_stop → RUN; next rise → 00:29.
- Running at 10:00: 1 rise → 09:59; load coincident with start_stop and rise → IDLE with the loaded value; assert RESET mid-count → all outputs 0 immediately, state IDLE.
- With COUNTDOWN_BLINK_EN: in PAUSE, tick_in=0 → blank=1 after 1 clk, tick_in=1 → blank=0; in RUN blank=0. Without the macro, blank=0 in all cases.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown clocked by the 1 Hz tick, with load / start-stop control and expiry flag.
// Latency: digits and status outputs update on the clk edge after the triggering input; a tick is seen one clk after its rising edge.
// Backpressure: none; load and start_stop are single-cycle pulses that are always accepted, with load taking priority over start_stop and start_stop over tick.
//
// Ports:
//   clk, RESET          100 MHz clock, asynchronous active-high reset
//   tick_in             1 Hz square wave; each rising edge is one second
//   load, load_min,     load pulse with binary minutes / seconds (clamped to
//   load_sec            MAX_MIN / MAX_SEC) -> IDLE with the loaded time
//   start_stop          toggles RUN / PAUSE; starts from IDLE when time is non-zero
//   min_tens..sec_ones  BCD digits of the remaining time
//   running, expired    registered state flags (RUN / EXPIRED)
//   done_pulse          single-cycle pulse on RUN -> EXPIRED
//   blank               display blank request
//
// Build option: define COUNTDOWN_BLINK_EN to flash the display (blank = ~tick_in,
// registered) while paused or expired. Without it blank is tied low.

module countdown_timer #(
  parameter int MAX_MIN = 99,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick_in,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start_stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       blank
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;

  logic       tick_d_q;
  logic       rise;

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  // One-second-decremented copy of the current digits.
  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;

  logic [6:0] min_clamped;
  logic [6:0] sec_clamped;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;

  logic       time_zero;
  logic       time_one;
  logic       do_dec;

  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       done_q,    done_d;

  // Binary 0..99 to packed BCD {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    tens = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(k * 10)) tens = 4'(k);
    end
    return {tens, 4'(v - 7'(tens) * 7'd10)};
  endfunction

  // ---------------------------------------------------------------------------
  // Tick edge detect
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) tick_d_q <= 1'b0;
    else       tick_d_q <= tick_in;
  end

  assign rise = tick_in & ~tick_d_q;

  // ---------------------------------------------------------------------------
  // Load clamp and BCD conversion
  // ---------------------------------------------------------------------------
  assign min_clamped = (load_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : load_min;
  assign sec_clamped = ({1'b0, load_sec} > 7'(MAX_SEC)) ? 7'(MAX_SEC) : {1'b0, load_sec};
  assign min_bcd     = to_bcd(min_clamped);
  assign sec_bcd     = to_bcd(sec_clamped);

  assign time_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                     (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
  assign time_one  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                     (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

  // ---------------------------------------------------------------------------
  // BCD decrement with borrow chain sec_ones -> sec_tens -> min_ones -> min_tens
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else if (sec_tens_q != 4'd0) begin
      dec_sec_tens = sec_tens_q - 4'd1;
      dec_sec_ones = 4'd9;
    end else if ((min_ones_q != 4'd0) || (min_tens_q != 4'd0)) begin
      dec_sec_tens = 4'd5;
      dec_sec_ones = 4'd9;
      if (min_ones_q != 4'd0) begin
        dec_min_ones = min_ones_q - 4'd1;
      end else begin
        dec_min_ones = 4'd9;
        dec_min_tens = min_tens_q - 4'd1;
      end
    end
  end

  // A tick only counts in RUN and only when no load / start_stop claims the cycle.
  // The zero guard keeps the digits from wrapping should RUN ever hold 00:00.
  assign do_dec = (state_q == ST_RUN) && rise && !load && !start_stop && !time_zero;

  // ---------------------------------------------------------------------------
  // Digit registers
  // ---------------------------------------------------------------------------
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (load) begin
      min_tens_d = min_bcd[7:4];
      min_ones_d = min_bcd[3:0];
      sec_tens_d = sec_bcd[7:4];
      sec_ones_d = sec_bcd[3:0];
    end else if (do_dec) begin
      min_tens_d = dec_min_tens;
      min_ones_d = dec_min_ones;
      sec_tens_d = dec_sec_tens;
      sec_ones_d = dec_sec_ones;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (load > start_stop > rise)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        ST_IDLE:    state_d = time_zero ? ST_IDLE : ST_RUN;
        ST_RUN:     state_d = ST_PAUSE;
        ST_PAUSE:   state_d = ST_RUN;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end else if (rise && (state_q == ST_RUN) && time_one) begin
      state_d = ST_EXPIRED;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the next state so the registered flags line up
  // with the state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
    done_d    = (state_q == ST_RUN) && (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  // Blank follows the inverted 1 Hz wave while paused or expired so the
  // display flashes; it is held off while idle or counting.
  logic blank_q, blank_d;

  always_comb begin
    blank_d = ((state_d == ST_PAUSE) || (state_d == ST_EXPIRED)) && !tick_in;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) blank_q <= 1'b0;
    else       blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign done_pulse = done_q;

endmodule
